nios_i2c_acc_led_pwm: RTL and testbench
=======================================

// Module: nios_i2c_acc_led_pwm
// PURPOSE
//  Downstream stage of the LED PIO. Takes the 10-bit LED pattern the PIO drives and applies
//  brightness PWM, optional blink and polarity before the board LED pins.
//  Has its own 4-word Avalon-MM slave (zero wait states) for Nios II control.
// PARAMETERS
//  NUM_LEDS    10  width of pattern_in / led_out
//  PWM_BITS    8   PWM counter and duty width; frame = 2^PWM_BITS ticks
//  PRESCALE    50  clk cycles per PWM tick (>=1)
//  BLINK_BITS  16  width of the blink half-period register, in PWM frames
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  pattern_in  in   NUM_LEDS  LED pattern from the PIO out_port
//  address     in   2         Avalon word address
//  chipselect  in   1         Avalon chip select
//  write_n     in   1         Avalon write strobe, active low
//  writedata   in   32        Avalon write data
//  readdata    out  32        Avalon read data, combinational from address
//  led_out     out  NUM_LEDS  registered LED drive
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset).
//  Registers (write when chipselect & ~write_n; unused bits read 0):
//   0 CTRL   [0]=enable [1]=blink_en [2]=invert. Reset 0.
//   1 DUTY   [PWM_BITS-1:0] target duty. Reset 0.
//   2 BLINK  [BLINK_BITS-1:0] blink half-period in frames. Reset 0.
//   3 STATUS RO. [0]=blink phase, [8+:PWM_BITS]=duty_eff. Writes ignored. Reset 0x1.
//  Reset: all registers, prescaler, pwm_cnt, blink_cnt, duty_eff and led_out = 0; phase = 1.
//  Reset mid-operation: everything returns to reset state on the next edge.
//  Timing chain (enable=1):
//   - Prescaler counts 0..PRESCALE-1; tick when it equals PRESCALE-1.
//   - On tick, pwm_cnt increments and wraps 2^PWM_BITS-1 -> 0.
//   - frame_end = tick & (pwm_cnt == all ones).
//  duty_eff is a shadow of DUTY, updated only on frame_end (glitch-free). A DUTY write on the
//   frame_end cycle misses it; duty_eff loads the old value and the new one applies next frame.
//  Blink: on frame_end, if blink_cnt >= BLINK-1 then blink_cnt=0 and phase toggles, else
//   blink_cnt++. The >= compare also covers BLINK shrinking mid-count. BLINK=0 or
//   blink_en=0 -> phase is forced to 1.
//  on = (pwm_cnt < duty_eff) & phase. duty 0 -> never on; duty 255 -> on 255/256 ticks.
//  led_out <= enable ? (on ? pattern_in : 0) ^ {NUM_LEDS{invert}} : 0
//   (one-cycle latency). Disabled forces 0 regardless of invert.
//  While enable=0: prescaler, pwm_cnt and blink_cnt held at 0; phase=1; duty_eff <= DUTY every
//   cycle. Re-enable starts a fresh frame at pwm_cnt=0.
//  pattern_in is sampled each cycle; no synchroniser (same clock domain as the PIO).
// CONFIGURATION
//  LED_PWM_FADE_EN defined: on each frame_end, duty_eff moves one step toward DUTY (+1 or -1,
//   holds when equal), giving a soft ramp. The enable=0 direct load still applies.
//  LED_PWM_FADE_EN undefined: duty_eff <= DUTY on frame_end (step change). No fade logic built.
// TESTING (sim with PRESCALE=2 -> frame = 512 clk)
//  1 reset held 3 cycles -> led_out=0; reading addr 3 gives 0x00000001; addr 0..2 read 0.
//  2 pattern_in=0x2A5, CTRL=1, DUTY=64 -> after the first frame_end, led_out=0x2A5 for 128 clk,
//    then 0x000 for 384 clk, repeating.
//  3 DUTY=0 -> led_out stays 0x000. DUTY=255 -> led_out=0x2A5 for 510 of every 512 clk.
//  4 CTRL=3, BLINK=2, DUTY=255 -> 2 frames PWM on, 2 frames all off; STATUS[0] toggles every
//    1024 clk. CTRL=7 -> off frames drive 0x3FF, on ticks drive 0x15A.
//  5 DUTY 64->128 written mid-frame -> no change until frame_end; write on the frame_end cycle
//    -> applies one frame later. FADE_EN: DUTY 0->4 reaches duty_eff=4 after exactly 4 frames.
//  6 CTRL=0 mid-frame -> led_out=0 next edge. Re-enable -> pwm_cnt restarts at 0.
//    reset asserted mid-blink -> STATUS=0x1, led_out=0.

Source files
------------

// File: rtl/nios_i2c_acc_led_pwm.sv
// LED PWM stage between the LED PIO and the board LED pins.
// Applies brightness PWM, optional blink and output polarity to pattern_in.
// Control is through a 4-word Avalon-MM slave with zero wait states.
// Optional feature macro: LED_PWM_FADE_EN (duty_eff ramps one step per frame
// toward DUTY instead of jumping to it).
module nios_i2c_acc_led_pwm #(
  parameter int NUM_LEDS   = 10,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 50,
  parameter int BLINK_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  // Bus: a write is accepted on any cycle with chipselect=1 and write_n=0;
  // there is no wait-request, and readdata follows address combinationally.
  logic                  reg_wr;
  logic [2:0]            ctrl;
  logic [PWM_BITS-1:0]   duty;
  logic [BLINK_BITS-1:0] blink;

  logic                  enable;
  logic                  blink_en;
  logic                  invert;

  logic [PS_W-1:0]       presc;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [PWM_BITS-1:0]   duty_eff;
  logic [PWM_BITS-1:0]   duty_next;
  logic                  phase;

  logic                  tick;
  logic                  frame_end;
  logic                  blink_active;
  logic                  blink_last;
  logic                  on;

  assign reg_wr       = chipselect & ~write_n;
  assign enable       = ctrl[0];
  assign blink_en     = ctrl[1];
  assign invert       = ctrl[2];
  assign tick         = enable & (presc == PS_MAX);
  assign frame_end    = tick & (&pwm_cnt);
  assign blink_active = blink_en & (blink != '0);
  assign blink_last   = blink_cnt >= (blink - BLINK_BITS'(1));
  assign on           = (pwm_cnt < duty_eff) & phase;

  // Value duty_eff takes at a frame boundary: a ramp step or a direct load.
`ifdef LED_PWM_FADE_EN
  always_comb begin
    duty_next = duty_eff;
    if (duty_eff < duty)      duty_next = duty_eff + 1'b1;
    else if (duty_eff > duty) duty_next = duty_eff - 1'b1;
  end
`else
  always_comb begin
    duty_next = duty;
  end
`endif

  // Control register file; STATUS is read-only so writes to it are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl  <= '0;
      duty  <= '0;
      blink <= '0;
    end else if (reg_wr) begin
      case (address)
        2'd0:    ctrl  <= writedata[2:0];
        2'd1:    duty  <= writedata[PWM_BITS-1:0];
        2'd2:    blink <= writedata[BLINK_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Timing chain: prescaler -> pwm counter -> frame-rate shadow and blink.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      duty_eff  <= '0;
      phase     <= 1'b1;
    end else if (!enable) begin
      presc     <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      duty_eff  <= duty;
      phase     <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (frame_end) duty_eff <= duty_next;
      if (!blink_active) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (frame_end) begin
        // >= rather than == so a BLINK shrunk below the count still wraps
        if (blink_last) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Registered LED drive; a disabled block forces 0 regardless of invert.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
    end else if (enable) begin
      led_out <= (on ? pattern_in : '0) ^ {NUM_LEDS{invert}};
    end else begin
      led_out <= '0;
    end
  end

  // Read mux; unused bits read as 0.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[2:0]            = ctrl;
      2'd1: readdata[PWM_BITS-1:0]   = duty;
      2'd2: readdata[BLINK_BITS-1:0] = blink;
      2'd3: begin
        readdata[0]            = phase;
        readdata[8 +: PWM_BITS] = duty_eff;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_i2c_acc_led_pwm.sv
// Bench for nios_i2c_acc_led_pwm with PRESCALE=2 (frame = 512 clk).
// Reference model works from elapsed enabled time; expected led_out and
// read data go into queues that a negedge monitor pops and compares.
module tb_nios_i2c_acc_led_pwm;

  localparam int NL       = 10;
  localparam int PRESCALE = 2;
  localparam int FRAME    = PRESCALE * 256;

  logic          clk;
  logic          reset;
  logic [NL-1:0] pattern_in;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NL-1:0] led_out;

  nios_i2c_acc_led_pwm #(
    .NUM_LEDS(NL), .PWM_BITS(8), .PRESCALE(PRESCALE), .BLINK_BITS(16)
  ) dut (
    .clk(clk), .reset(reset), .pattern_in(pattern_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .led_out(led_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [NL-1:0] exp_q[$];
  logic [31:0]   rd_exp_q[$];
  logic [1:0]    rd_addr_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  // ---------------- reference model state ----------------
  logic [2:0]  m_ctrl;
  logic [7:0]  m_duty;
  logic [15:0] m_blink;
  int          m_t;      // enabled clocks since enable rose
  int          m_deff;   // effective duty
  int          m_k;      // frame ends seen while blink active
  logic        m_phase;

  // Reference model: each edge, predict led_out from pre-edge state.
  initial begin
    logic [NL-1:0] e;
    logic [NL-1:0] inv_mask;
    int  pwm;
    bit  en, fe, bact, on;
    m_ctrl = '0; m_duty = '0; m_blink = '0;
    m_t = 0; m_deff = 0; m_k = 0; m_phase = 1'b1;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_ctrl = '0; m_duty = '0; m_blink = '0;
        m_t = 0; m_deff = 0; m_k = 0; m_phase = 1'b1;
        exp_q.push_back('0);
      end else begin
        en   = m_ctrl[0];
        pwm  = (m_t / PRESCALE) % 256;
        fe   = en && ((m_t % FRAME) == FRAME - 1);
        bact = en && m_ctrl[1] && (m_blink != 0);
        on   = (pwm < m_deff) && m_phase;
        inv_mask = m_ctrl[2] ? {NL{1'b1}} : '0;
        e = '0;
        if (en) e = (on ? pattern_in : '0) ^ inv_mask;
        exp_q.push_back(e);
        if (!en) begin
          m_t = 0; m_deff = int'(m_duty); m_k = 0; m_phase = 1'b1;
        end else begin
          m_t++;
          if (fe) begin
`ifdef LED_PWM_FADE_EN
            if (m_deff < int'(m_duty)) m_deff++;
            else if (m_deff > int'(m_duty)) m_deff--;
`else
            m_deff = int'(m_duty);
`endif
          end
          if (!bact) begin
            m_k = 0; m_phase = 1'b1;
          end else if (fe) begin
            m_k++;
            m_phase = ((m_k / int'(m_blink)) % 2) == 0;
          end
        end
        if (chipselect && !write_n) begin
          case (address)
            2'd0: m_ctrl  = writedata[2:0];
            2'd1: m_duty  = writedata[7:0];
            2'd2: m_blink = writedata[15:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: compare led_out every cycle and any pending register read.
  initial begin
    logic [NL-1:0] e;
    logic [31:0]   r;
    logic [1:0]    a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (led_out !== e) begin
          n_errors++;
          if (n_errors <= 30)
            $display("FAIL led_out t=%0t got=%h expected=%h", $time, led_out, e);
        end
      end
      if (rd_exp_q.size() > 0) begin
        r = rd_exp_q.pop_front();
        a = rd_addr_q.pop_front();
        n_checks++;
        if (readdata !== r) begin
          n_errors++;
          if (n_errors <= 30)
            $display("FAIL readdata addr=%0d t=%0t got=%h expected=%h", a, $time, readdata, r);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    logic [31:0] r;
    @(posedge clk); #1;
    address = a;
    r = '0;
    case (a)
      2'd0: r[2:0]  = m_ctrl;
      2'd1: r[7:0]  = m_duty;
      2'd2: r[15:0] = m_blink;
      default: begin r[0] = m_phase; r[15:8] = 8'(m_deff); end
    endcase
    rd_exp_q.push_back(r);
    rd_addr_q.push_back(a);
    @(negedge clk);
  endtask

  // Write DUTY so that the write lands on a frame_end edge.
  task automatic wr_duty_on_frame_end(input logic [7:0] d);
    int  i;
    bit  found;
    found = 1'b0;
    for (i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk); #1;
      if (m_ctrl[0] && (m_t % FRAME) == FRAME - 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL frame_end_wait got=timeout expected=frame_end within %0d clk", 2 * FRAME);
    end else begin
      chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = {24'd0, d};
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    reset = 1'b1; pattern_in = '0; address = '0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state readback
    for (int a = 0; a < 4; a++) rd(2'(a));

    // basic PWM at 25%
    pattern_in = 10'h2A5;
    wr(2'd1, 32'd64);
    wr(2'd0, 32'd1);
    run(3 * FRAME);
    rd(2'd3);

    // duty boundaries
    wr(2'd1, 32'd0);
    run(2 * FRAME + 20);
    wr(2'd1, 32'd255);
    run(2 * FRAME + 20);
    rd(2'd3);

    // blink, then blink with invert
    wr(2'd2, 32'd2);
    wr(2'd0, 32'd3);
    for (int i = 0; i < 5; i++) begin run(FRAME); rd(2'd3); end
    wr(2'd0, 32'd7);
    run(4 * FRAME);
    rd(2'd0); rd(2'd2);

    // duty shadow: mid-frame write, then write on the frame_end edge
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd64);
    run(FRAME + 100);
    wr(2'd1, 32'd128);
    rd(2'd3);
    wr_duty_on_frame_end(8'd32);
    rd(2'd3);
    run(FRAME + 10);
    rd(2'd3);

    // fade/step from 0 to 4
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd4);
    for (int i = 0; i < 5; i++) begin run(FRAME); rd(2'd3); end

    // disable mid-frame, re-enable restarts frame
    run(137);
    wr(2'd0, 32'd0);
    run(20);
    wr(2'd0, 32'd5);
    run(FRAME + 50);

    // reset mid-blink
    wr(2'd2, 32'd1);
    wr(2'd0, 32'd3);
    run(FRAME + 200);
    do_reset(2);
    rd(2'd3);
    rd(2'd0);
    run(5);

    // randomized operation
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: wr(2'd1, 32'($urandom_range(0, 255)));
        1: wr(2'd0, 32'($urandom_range(0, 7)));
        2: begin
          wr(2'd0, {29'd0, m_ctrl & 3'b101});
          wr(2'd2, 32'($urandom_range(0, 3)));
          wr(2'd0, 32'($urandom_range(0, 7)));
        end
        3: wr(2'd3, $urandom);
        default: wr(2'd1, 32'($urandom_range(0, 1) * 255));
      endcase
      for (int j = 0; j < 8; j++) begin
        pattern_in = NL'($urandom);
        run($urandom_range(5, 80));
      end
      rd(2'($urandom_range(0, 3)));
    end

    run(4);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
